// File: rtl/spi_flash_arbiter.sv
// Two-requester SPI flash read arbiter: round-robin grant, 0x03 read of one
// 32-bit little-endian word per transaction over a mode-0 SPI link.
module spi_flash_arbiter #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [23:0] req0_addr,
    output logic        req0_ready,
    output logic [31:0] req0_rdata,
    input  logic        req1_valid,
    input  logic [23:0] req1_addr,
    output logic        req1_ready,
    output logic [31:0] req1_rdata,
    output logic        sck,
    output logic        sdo,
    input  logic        sdi,
    output logic        cs
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

    state_t      state_reg, state_next;
    logic        grant_idx_reg, grant_idx_next;
    logic        last_grant_reg, last_grant_next;
    logic [31:0] tx_reg, tx_next;
    logic [31:0] rx_reg, rx_next;
    logic [6:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  phase_cnt_reg, phase_cnt_next;
    logic        sck_reg, sck_next;
    logic [7:0]  gap_cnt_reg, gap_cnt_next;
    logic        rdata_load;
    logic        grant_sel;
    logic [23:0] addr_sel;
    logic [1:0]  req_valid;
    logic [1:0]  ready;
    logic [31:0] rx_word;
    logic [31:0] rdata_reg [2];

    assign req_valid = {req1_valid, req0_valid};
    // On contention the requester that was not served last wins
    assign grant_sel = (&req_valid) ? ~last_grant_reg : req_valid[1];
    assign addr_sel  = grant_sel ? req1_addr : req0_addr;
    // First received byte sits in rx_reg[31:24]; it belongs in the low byte
    assign rx_word   = {rx_reg[7:0], rx_reg[15:8], rx_reg[23:16], rx_reg[31:24]};

    always_comb begin
        state_next      = state_reg;
        grant_idx_next  = grant_idx_reg;
        last_grant_next = last_grant_reg;
        tx_next         = tx_reg;
        rx_next         = rx_reg;
        bit_cnt_next    = bit_cnt_reg;
        phase_cnt_next  = phase_cnt_reg;
        sck_next        = sck_reg;
        gap_cnt_next    = gap_cnt_reg;
        rdata_load      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    state_next      = SHIFT;
                    grant_idx_next  = grant_sel;
                    last_grant_next = grant_sel;
                    tx_next         = {8'h03, addr_sel};
                    bit_cnt_next    = 7'd0;
                    phase_cnt_next  = 8'd0;
                    sck_next        = 1'b0;
                end
            end
            SHIFT: begin
                if (phase_cnt_reg == PHASE_LAST) begin
                    phase_cnt_next = 8'd0;
                    if (!sck_reg) begin
                        // Rising SCK edge: flash data is sampled here
                        sck_next = 1'b1;
                        if (bit_cnt_reg >= 7'd32) begin
                            rx_next = {rx_reg[30:0], sdi};
                        end
                    end else begin
                        sck_next     = 1'b0;
                        bit_cnt_next = bit_cnt_reg + 7'd1;
                        tx_next      = {tx_reg[30:0], 1'b0};
                        if (bit_cnt_reg == 7'd63) begin
                            state_next = DONE;
                            rdata_load = 1'b1;
                        end
                    end
                end else begin
                    phase_cnt_next = phase_cnt_reg + 8'd1;
                end
            end
            DONE: begin
                state_next   = GAP;
                gap_cnt_next = 8'd0;
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_idx_reg  <= 1'b0;
            last_grant_reg <= 1'b1;
            tx_reg         <= 32'd0;
            rx_reg         <= 32'd0;
            bit_cnt_reg    <= 7'd0;
            phase_cnt_reg  <= 8'd0;
            sck_reg        <= 1'b0;
            gap_cnt_reg    <= 8'd0;
        end else begin
            state_reg      <= state_next;
            grant_idx_reg  <= grant_idx_next;
            last_grant_reg <= last_grant_next;
            tx_reg         <= tx_next;
            rx_reg         <= rx_next;
            bit_cnt_reg    <= bit_cnt_next;
            phase_cnt_reg  <= phase_cnt_next;
            sck_reg        <= sck_next;
            gap_cnt_reg    <= gap_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_reg[gi] <= 32'd0;
                end else if (rdata_load && (grant_idx_reg == 1'(gi))) begin
                    rdata_reg[gi] <= rx_word;
                end
            end
            assign ready[gi] = (state_reg == DONE) && (grant_idx_reg == 1'(gi));
        end
    endgenerate

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign req0_rdata = rdata_reg[0];
    assign req1_rdata = rdata_reg[1];

    // tx_reg drains to zero after the command/address, keeping sdo low while reading
    assign cs  = (state_reg != SHIFT);
    assign sck = (state_reg == SHIFT) && sck_reg;
    assign sdo = (state_reg == SHIFT) && tx_reg[31];

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: behavioural SPI flash per DUT, scoreboard of
// expected transactions for the CLK_DIV=2 instance, direct checks for CLK_DIV=1.
module tb_spi_flash_arbiter;

    localparam int GAP_A = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic srst = 1'b1;

    logic        req0_valid_a, req1_valid_a, req0_ready_a, req1_ready_a;
    logic [23:0] req0_addr_a, req1_addr_a;
    logic [31:0] req0_rdata_a, req1_rdata_a;
    logic        sck_a, sdo_a, cs_a;
    logic        sdi_a = 1'b0;

    logic        req0_valid_b, req1_valid_b, req0_ready_b, req1_ready_b;
    logic [23:0] req0_addr_b, req1_addr_b;
    logic [31:0] req0_rdata_b, req1_rdata_b;
    logic        sck_b, sdo_b, cs_b;
    logic        sdi_b = 1'b0;

    spi_flash_arbiter #(.CLK_DIV(2), .CS_GAP(GAP_A)) dut_a (
        .clk(clk), .reset(srst),
        .req0_valid(req0_valid_a), .req0_addr(req0_addr_a),
        .req0_ready(req0_ready_a), .req0_rdata(req0_rdata_a),
        .req1_valid(req1_valid_a), .req1_addr(req1_addr_a),
        .req1_ready(req1_ready_a), .req1_rdata(req1_rdata_a),
        .sck(sck_a), .sdo(sdo_a), .sdi(sdi_a), .cs(cs_a)
    );

    spi_flash_arbiter #(.CLK_DIV(1), .CS_GAP(2)) dut_b (
        .clk(clk), .reset(srst),
        .req0_valid(req0_valid_b), .req0_addr(req0_addr_b),
        .req0_ready(req0_ready_b), .req0_rdata(req0_rdata_b),
        .req1_valid(req1_valid_b), .req1_addr(req1_addr_b),
        .req1_ready(req1_ready_b), .req1_rdata(req1_rdata_b),
        .sck(sck_b), .sdo(sdo_b), .sdi(sdi_b), .cs(cs_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Flash contents: the word stored little-endian at each address
    function automatic logic [31:0] flash_word(input logic [23:0] a);
        if (a == 24'h012345) return 32'hDEADBEEF;
        return {a[7:0], a} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic stream_bit(input logic [31:0] w, input int s);
        int idx;
        idx = 8 * (s / 8) + 7 - (s % 8);
        return w[idx];
    endfunction

    // Flash models: capture command/address on SCK rise, drive data after SCK fall
    logic        fa_prev = 1'b0, fb_prev = 1'b0;
    int          fa_rise = 0, fb_rise = 0;
    logic [31:0] fa_cmd = 32'd0, fb_cmd = 32'd0;

    always @(negedge clk) begin
        if (cs_a) begin
            fa_rise <= 0;
            sdi_a   <= 1'b0;
        end else begin
            if (sck_a && !fa_prev) begin
                if (fa_rise < 32) fa_cmd <= {fa_cmd[30:0], sdo_a};
                fa_rise <= fa_rise + 1;
            end
            if (!sck_a && fa_prev && fa_rise >= 32 && fa_rise < 64)
                sdi_a <= stream_bit(flash_word(fa_cmd[23:0]), fa_rise - 32);
        end
        fa_prev <= sck_a;
    end

    always @(negedge clk) begin
        if (cs_b) begin
            fb_rise <= 0;
            sdi_b   <= 1'b0;
        end else begin
            if (sck_b && !fb_prev) begin
                if (fb_rise < 32) fb_cmd <= {fb_cmd[30:0], sdo_b};
                fb_rise <= fb_rise + 1;
            end
            if (!sck_b && fb_prev && fb_rise >= 32 && fb_rise < 64)
                sdi_b <= stream_bit(flash_word(fb_cmd[23:0]), fb_rise - 32);
        end
        fb_prev <= sck_b;
    end

    typedef struct packed {
        logic        idx;
        logic [23:0] addr;
    } exp_t;

    exp_t sb[$];

    // Scoreboard consumer for dut_a
    initial begin
        exp_t e;
        logic who;
        forever begin
            @(posedge clk);
            #1;
            if (req0_ready_a || req1_ready_a) begin
                who = req1_ready_a;
                check("both_ready", req0_ready_a & req1_ready_a, 0);
                check("sb_pending", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("grant_idx", who, e.idx);
                    check("sdo_stream", fa_cmd, {8'h03, e.addr});
                    check("rdata", who ? req1_rdata_a : req0_rdata_a, flash_word(e.addr));
                    $display("txn: req%0d addr=%06h cmd=%08h rdata=%08h", who, e.addr, fa_cmd,
                             who ? req1_rdata_a : req0_rdata_a);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a(output int cyc);
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (!(req0_ready_a || req1_ready_a) && cyc < 2000);
        check("ready_in_time", cyc < 2000, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, n, csl;
        logic r0b_seen;
        logic [23:0] a_addr [2];
        logic [23:0] b_addr [2];

        req0_valid_a = 0; req1_valid_a = 0; req0_addr_a = 0; req1_addr_a = 0;
        req0_valid_b = 0; req1_valid_b = 0; req0_addr_b = 0; req1_addr_b = 0;
        srst = 1;
        tick(3);
        check("rst_cs", cs_a, 1);
        check("rst_sck", sck_a, 0);
        check("rst_sdo", sdo_a, 0);
        check("rst_ready0", req0_ready_a, 0);
        check("rst_ready1", req1_ready_a, 0);
        check("rst_rdata0", req0_rdata_a, 0);
        check("rst_rdata1", req1_rdata_a, 0);

        // Single read from requester 0
        srst = 0;
        req0_addr_a = 24'h012345;
        req0_valid_a = 1;
        sb.push_back('{idx: 1'b0, addr: 24'h012345});
        wait_ready_a(cyc);
        check("latency_single", cyc, 257);
        check("single_no_ready1", req1_ready_a, 0);
        req0_valid_a = 0;
        tick(3);
        check("rdata_hold", req0_rdata_a, 32'hDEADBEEF);

        // Both requesters continuously valid from reset
        srst = 1;
        tick(2);
        srst = 0;
        a_addr[0] = 24'h100200; a_addr[1] = 24'h0000FF;
        b_addr[0] = 24'h3A5C7E; b_addr[1] = 24'hC0FFEE;
        req0_addr_a = a_addr[0]; req1_addr_a = b_addr[0];
        req0_valid_a = 1; req1_valid_a = 1;
        sb.push_back('{idx: 1'b0, addr: a_addr[0]});
        sb.push_back('{idx: 1'b1, addr: b_addr[0]});
        sb.push_back('{idx: 1'b0, addr: a_addr[1]});
        sb.push_back('{idx: 1'b1, addr: b_addr[1]});
        for (int t = 0; t < 4; t++) begin
            wait_ready_a(cyc);
            check("rr_order", req1_ready_a, t % 2);
            if (t == 0) req0_addr_a = a_addr[1];
            if (t == 1) req1_addr_a = b_addr[1];
            if (t == 2) req0_valid_a = 0;
            if (t == 3) req1_valid_a = 0;
            if (t == 0) begin
                // cs-high cycles after the ready cycle until the next SHIFT
                n = 0;
                tick(1);
                while (cs_a && n < 50) begin
                    n++;
                    tick(1);
                end
                check("cs_gap", n, GAP_A + 1);
            end
        end

        // Reset in the middle of a requester-1 transaction
        tick(4);
        req1_addr_a = 24'h00ABCD;
        req1_valid_a = 1;
        sb.push_back('{idx: 1'b1, addr: 24'h00ABCD});
        tick(100);
        srst = 1;
        sb.delete();
        tick(1);
        check("abort_cs", cs_a, 1);
        check("abort_sck", sck_a, 0);
        check("abort_sdo", sdo_a, 0);
        check("abort_ready1", req1_ready_a, 0);
        check("abort_rdata1", req1_rdata_a, 0);
        tick(1);
        srst = 0;
        sb.push_back('{idx: 1'b1, addr: 24'h00ABCD});
        wait_ready_a(cyc);
        check("latency_restart", cyc, 257);
        req1_valid_a = 0;

        // Address change and valid drop right after grant
        tick(4);
        req0_addr_a = 24'h000010;
        req0_valid_a = 1;
        sb.push_back('{idx: 1'b0, addr: 24'h000010});
        tick(1);
        req0_addr_a = 24'h000020;
        req0_valid_a = 0;
        wait_ready_a(cyc);
        check("latency_after_grant", cyc, 256);

        // CLK_DIV=1 instance, top address
        tick(2);
        req1_addr_b = 24'hFFFFFF;
        req1_valid_b = 1;
        cyc = 0; csl = 0; r0b_seen = 0;
        do begin
            tick(1);
            cyc++;
            if (!cs_b) csl++;
            if (req0_ready_b) r0b_seen = 1;
        end while (!req1_ready_b && cyc < 1000);
        req1_valid_b = 0;
        $display("txn: div1 req1 addr=ffffff cmd=%08h rdata=%08h", fb_cmd, req1_rdata_b);
        check("div1_latency", cyc, 129);
        check("div1_cs_low", csl, 128);
        check("div1_rises", fb_rise, 64);
        check("div1_stream", fb_cmd, 32'h03FFFFFF);
        check("div1_rdata", req1_rdata_b, flash_word(24'hFFFFFF));
        check("div1_no_ready0", r0b_seen, 0);

        tick(4);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_flash_arbiter.md
SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, giving clk cycles per SCK half-period (legal 1..255).
REQ-002 The block SHALL have parameter CS_GAP, default 2, giving minimum clk cycles CS stays high between transactions (legal 1..255).
REQ-003 clk  input  1  system clock; sole clock domain; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 read request; held high until req0_ready.
REQ-006 req0_addr  input  24  requester 0 flash byte address.
REQ-007 req0_ready  output  1  one-cycle pulse: req0_rdata valid, request done.
REQ-008 req0_rdata  output  32  word read for requester 0.
REQ-009 req1_valid, req1_addr[23:0], req1_ready, req1_rdata[31:0] SHALL match REQ-005..008 for requester 1.
REQ-010 sck  output  1  SPI clock, mode 0, idle low.
REQ-011 sdo  output  1  SPI data to flash.
REQ-012 sdi  input  1  SPI data from flash.
REQ-013 cs  output  1  SPI chip select, active low.

Function
REQ-014 States SHALL be IDLE, SHIFT, DONE, GAP; IDLE->SHIFT on grant; SHIFT->DONE after 64th bit; DONE->GAP after 1 cycle; GAP->IDLE after CS_GAP cycles.
REQ-015 Grant SHALL be evaluated only in IDLE; single requester valid -> that requester; both valid -> requester not granted last (round-robin).
REQ-016 The last-grant pointer SHALL reset to 1, so requester 0 wins the first simultaneous request.
REQ-017 At grant, address and requester index SHALL be latched; later changes to reqN_addr/reqN_valid SHALL not affect the transaction.
REQ-018 SHIFT SHALL transfer 64 bits: 8-bit command 0x03, then 24-bit address, both MSB first, then 32 read bits.
REQ-019 Each bit SHALL last 2*CLK_DIV cycles: CLK_DIV cycles sck=0, then CLK_DIV cycles sck=1.
REQ-020 sdo SHALL update on the first cycle of each bit's low phase and hold through the bit; sdo=0 during the 32 read bits and outside SHIFT.
REQ-021 sdi SHALL be sampled on the clk edge where sck transitions 0->1 (first high-phase cycle).
REQ-022 Read bytes SHALL be assembled little-endian: first received byte -> rdata[7:0], each byte MSB first; fourth byte -> rdata[31:24].
REQ-023 cs SHALL be 0 in all SHIFT cycles and 1 in IDLE, DONE, GAP.
REQ-024 In DONE, only the granted requester's ready SHALL pulse high for exactly one cycle; its rdata SHALL present the assembled word then and hold until its next DONE.
REQ-025 Latency: valid sampled in IDLE at cycle 0 -> SHIFT cycles 1..128*CLK_DIV -> ready high at cycle 128*CLK_DIV+1 (257 for CLK_DIV=2).
REQ-026 A requester dropping valid mid-transaction SHALL not abort it; its ready pulse SHALL still be issued.
REQ-027 A request arriving during SHIFT/DONE/GAP SHALL wait; it is granted on the first IDLE cycle in which it is valid.
REQ-028 Bit and phase counters SHALL not wrap: the bit counter terminates at 64, the phase counter at CLK_DIV-1.

Reset
REQ-029 On reset: state IDLE, cs=1, sck=0, sdo=0, req0_ready=0, req1_ready=0, req0_rdata=0, req1_rdata=0, last-grant=1, all counters 0.
REQ-030 Reset asserted mid-SHIFT SHALL force the REQ-029 values on the next clk edge; no ready pulse for the aborted transaction; a still-valid request is re-arbitrated from IDLE after reset deasserts.

Verification
REQ-031 req0 only, addr 0x012345, flash model returns bytes 0xEF,0xBE,0xAD,0xDE, CLK_DIV=2 -> sdo stream 0x03012345, req0_ready pulse at cycle 257, req0_rdata=0xDEADBEEF, req1_ready never high.
REQ-032 req0 and req1 valid together from reset -> req0 served first, then req1 granted on first IDLE cycle after GAP; cs high for exactly CS_GAP+1 cycles between transactions.
REQ-033 Both valid continuously for 4 transactions -> grant order 0,1,0,1.
REQ-034 Reset pulsed at cycle 100 of a req1 transaction -> next edge cs=1, sck=0, no req1_ready; after reset release with req1_valid high, full transaction restarts with command 0x03.
REQ-035 CLK_DIV=1, req1 addr 0xFFFFFF -> sck toggles every cycle, 64 rising edges, req1_ready at cycle 129.
REQ-036 req0_addr changed from 0x000010 to 0x000020 one cycle after grant -> transmitted address remains 0x000010.
